// File: rtl/enc_pkg.sv
// Shared definitions for the sequential set-bit scanner and its priority encoder.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package enc_pkg;

    // Scanner FSM: waiting for a vector, or emitting its set-bit indices.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Scan-order encodings for the MSB_FIRST parameter.
    localparam int MSB_FIRST_LO = 0;   // lowest set bit first
    localparam int MSB_FIRST_HI = 1;   // highest set bit first

    // Ceiling log2, used to size index outputs at elaboration time.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Generic WIDTH-to-log2(WIDTH) priority encoder, lowest or highest set bit wins.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: vec = request vector; idx = winning bit index (0 when vec is empty);
//        any = at least one bit of vec is set.
module prio_enc
    import enc_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  MSB_FIRST = MSB_FIRST_LO,
    localparam int IDX_W     = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Later loop iterations override earlier ones, so the loop direction
    // picks which end of the vector has priority.
    always_comb begin
        idx = '0;
        any = |vec;
        if (MSB_FIRST == MSB_FIRST_HI) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/enc_scan_seq.sv
// Accepts a request vector and emits the index of each set bit, one beat per bit.
// Latency: first beat the cycle after the input handshake; K set bits take K+1 cycles.
// Backpressure: out_ready low holds the current beat stable; in_ready is low for the whole scan.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_vec input handshake;
//        out_valid/out_ready handshake with out_idx, out_last, out_zero per beat.
module enc_scan_seq
    import enc_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  MSB_FIRST = MSB_FIRST_LO,
    localparam int IDX_W     = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic               zero_q, zero_d;

    logic [IDX_W-1:0]   enc_idx;
    logic               enc_any;
    logic               multi;
    logic               last_c;

    prio_enc #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio_enc (
        .vec (pending_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    // x & (x-1) strips the lowest set bit; anything left means 2+ bits pending.
    assign multi  = |(pending_q & (pending_q - ONE));
    // An all-zero vector still produces exactly one (final) beat.
    assign last_c = zero_q | (enc_any & ~multi);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_d    = zero_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_last  = 1'b0;
        out_zero  = 1'b0;
        case (state_q)
            IDLE: begin
                // Not ready while reset is held, even though state is already IDLE.
                in_ready = ~rst;
                if (in_valid) begin
                    pending_d = in_vec;
                    zero_d    = (in_vec == '0);
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                out_valid = 1'b1;
                out_idx   = enc_idx;
                out_last  = last_c;
                out_zero  = zero_q;
                if (out_ready) begin
                    if (last_c) begin
                        state_d   = IDLE;
                        pending_d = '0;
                        zero_d    = 1'b0;
                    end else begin
                        pending_d = pending_q & ~(ONE << enc_idx);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_q    <= zero_d;
        end
    end

endmodule

// File: tb/tb_enc_scan_seq.sv
module tb_enc_scan_seq;

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
        logic       zero;
    } beat_t;

    typedef struct {
        logic [7:0]  vec;
        int          n;      // expected number of beats
        logic [31:0] idxs;   // nibble k = index of beat k
        logic        zero;
    } vec8_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid8 = 1'b0, in_ready8;
    logic [7:0]  in_vec8 = '0;
    logic        out_valid8, out_ready8 = 1'b1;
    logic [2:0]  out_idx8;
    logic        out_last8, out_zero8;

    logic        in_valid16 = 1'b0, in_ready16;
    logic [15:0] in_vec16 = '0;
    logic        out_valid16, out_ready16 = 1'b1;
    logic [3:0]  out_idx16;
    logic        out_last16, out_zero16;

    int    ncmp = 0;
    int    nfail = 0;
    beat_t q8[$];
    beat_t q16[$];
    beat_t e8, e16;
    vec8_t tbl[7];

    always #5 clk = ~clk;

    enc_scan_seq #(.WIDTH(8), .MSB_FIRST(0)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_vec(in_vec8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_idx(out_idx8), .out_last(out_last8), .out_zero(out_zero8)
    );

    enc_scan_seq #(.WIDTH(16), .MSB_FIRST(1)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_vec(in_vec16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out_idx(out_idx16), .out_last(out_last16), .out_zero(out_zero16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pop and compare each accepted output beat.
    always @(negedge clk) begin
        if (!rst && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                ncmp++;
                nfail++;
                $display("FAIL beat8_unexpected: got idx %0d, required no beat", out_idx8);
            end else begin
                e8 = q8.pop_front();
                chk("beat8_idx",  32'(out_idx8),  32'(e8.idx));
                chk("beat8_last", 32'(out_last8), 32'(e8.last));
                chk("beat8_zero", 32'(out_zero8), 32'(e8.zero));
            end
        end
        if (!rst && out_valid16 && out_ready16) begin
            if (q16.size() == 0) begin
                ncmp++;
                nfail++;
                $display("FAIL beat16_unexpected: got idx %0d, required no beat", out_idx16);
            end else begin
                e16 = q16.pop_front();
                chk("beat16_idx",  32'(out_idx16),  32'(e16.idx));
                chk("beat16_last", 32'(out_last16), 32'(e16.last));
                chk("beat16_zero", 32'(out_zero16), 32'(e16.zero));
            end
        end
    end

    task automatic send8(input logic [7:0] vec, input int n, input logic [31:0] idxs, input logic zero);
        int    t;
        beat_t b;
        t = 0;
        while (!in_ready8 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("in_ready8_wait", 32'(in_ready8), 32'd1);
        for (int k = 0; k < n; k++) begin
            b.idx  = idxs[4*k +: 4];
            b.last = (k == n - 1);
            b.zero = zero;
            q8.push_back(b);
        end
        in_valid8 = 1'b1;
        in_vec8   = vec;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        in_vec8   = 8'($urandom);   // must not disturb the scan in progress
        chk("first_valid8", 32'(out_valid8), 32'd1);
    endtask

    task automatic wait_idle8(input int exp_cycles);
        int k;
        k = 0;
        while (!in_ready8 && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        chk("idle_gap8", 32'(k), 32'(exp_cycles));
        chk("sb_empty8", 32'(q8.size()), 32'd0);
    endtask

    task automatic send16(input logic [15:0] vec, input logic [3:0] i0, input int n, input logic [3:0] i1);
        int    t;
        beat_t b;
        t = 0;
        while (!in_ready16 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("in_ready16_wait", 32'(in_ready16), 32'd1);
        b.idx = i0; b.last = (n == 1); b.zero = 1'b0;
        q16.push_back(b);
        if (n == 2) begin
            b.idx = i1; b.last = 1'b1; b.zero = 1'b0;
            q16.push_back(b);
        end
        in_valid16 = 1'b1;
        in_vec16   = vec;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        in_vec16   = 16'($urandom);
        chk("first_valid16", 32'(out_valid16), 32'd1);
    endtask

    task automatic wait_idle16(input int exp_cycles);
        int k;
        k = 0;
        while (!in_ready16 && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        chk("idle_gap16", 32'(k), 32'(exp_cycles));
        chk("sb_empty16", 32'(q16.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{8'h01, 1, 32'h0000_0000, 1'b0};
        tbl[1] = '{8'h96, 4, 32'h0000_7421, 1'b0};
        tbl[2] = '{8'h00, 1, 32'h0000_0000, 1'b1};
        tbl[3] = '{8'h80, 1, 32'h0000_0007, 1'b0};
        tbl[4] = '{8'hFF, 8, 32'h7654_3210, 1'b0};
        tbl[5] = '{8'h81, 2, 32'h0000_0070, 1'b0};
        tbl[6] = '{8'h24, 2, 32'h0000_0052, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid8", 32'(out_valid8), 32'd0);
        chk("rst_in_ready8",  32'(in_ready8),  32'd0);
        chk("rst_out_idx8",   32'(out_idx8),   32'd0);
        chk("rst_out_last8",  32'(out_last8),  32'd0);
        chk("rst_out_zero8",  32'(out_zero8),  32'd0);
        chk("rst_in_ready16", 32'(in_ready16), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready8",  32'(in_ready8),  32'd1);
        chk("post_rst_out_valid8", 32'(out_valid8), 32'd0);

        // Table-driven vectors with out_ready held high
        out_ready8 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send8(tbl[i].vec, tbl[i].n, tbl[i].idxs, tbl[i].zero);
            wait_idle8(tbl[i].n);
        end

        // Backpressure: first beat held for 4 cycles
        out_ready8 = 1'b0;
        send8(8'h24, 2, 32'h0000_0052, 1'b0);
        chk("bp_idx_0",  32'(out_idx8),  32'd2);
        chk("bp_last_0", 32'(out_last8), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(out_valid8), 32'd1);
            chk("bp_idx",   32'(out_idx8),   32'd2);
            chk("bp_last",  32'(out_last8),  32'd0);
            chk("bp_zero",  32'(out_zero8),  32'd0);
        end
        out_ready8 = 1'b1;
        wait_idle8(2);

        // Reset after the first beat of 8'hF0
        send8(8'hF0, 4, 32'h0000_7654, 1'b0);
        @(posedge clk); #1;
        chk("mid_idx_before_rst", 32'(out_idx8), 32'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_out_valid8", 32'(out_valid8), 32'd0);
        chk("mid_rst_in_ready8",  32'(in_ready8),  32'd0);
        q8.delete();
        rst = 1'b0;
        #1;
        chk("mid_rel_in_ready8", 32'(in_ready8), 32'd1);
        send8(8'h02, 1, 32'h0000_0001, 1'b0);
        wait_idle8(1);

        // WIDTH=16, highest bit first
        send16(16'h8001, 4'd15, 2, 4'd0);
        wait_idle16(2);
        for (int b = 0; b < 16; b++) begin
            logic [15:0] v;
            v = 16'd1 << b;
            send16(v, 4'(b), 1, 4'd0);
            wait_idle16(1);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("final_q8_empty",  32'(q8.size()),  32'd0);
        chk("final_q16_empty", 32'(q16.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
